// File: rtl/lfsr_addr_cfg_pkg.sv
// Shared types and constants for the LFSR_ADDR configuration-port arbiter.
// Register offsets describe the slave's map; RESP codes follow AXI4-Lite.
package lfsr_addr_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lfsr_addr_cfg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is chosen; the winner is remembered only when the grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant_q;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
    last_grant_d = (take && gnt_valid) ? gnt_idx : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/lfsr_addr_cfg_arbiter.sv
// Shares the LFSR_ADDR AXI4-Lite slave port between two command requesters,
// one single-beat access at a time, returning the response to its owner.
module lfsr_addr_cfg_arbiter
  import lfsr_addr_cfg_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_we,
  input  logic [2*C_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*C_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                    rsp_valid,
  input  logic [1:0]                    rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic            in_idle;
  logic            gnt_valid;
  logic            gnt_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            aw_done;
  logic            w_done;
  logic            unused_addr_lsbs;

  assign in_idle = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (req_valid & {2{in_idle}}),
    .take      (in_idle),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Byte lanes are always full words, so the captured address is word-aligned.
  assign sel_addr  = gnt_idx ? {req_addr[2*AW-1:AW+2], 2'b00} : {req_addr[AW-1:2], 2'b00};
  assign sel_wdata = gnt_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign unused_addr_lsbs = ^{req_addr[AW+1:AW], req_addr[1:0]};

  // Gated by ARESETN so no command is accepted while the block is held in reset.
  assign req_ready = (in_idle && gnt_valid && ARESETN) ? onehot2(gnt_idx) : 2'b00;

  assign aw_done = ~awvalid_q | m_axi_awready;
  assign w_done  = ~wvalid_q | m_axi_wready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (req_we[gnt_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        // AW and W retire independently; move on once both have handshaken.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = onehot2(owner_q);
          state_d     = RESP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_valid_d = onehot2(owner_q);
          state_d     = RESP;
        end
      end
      RESP: begin
        if ((rsp_valid_q & rsp_ready) != 2'b00) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_lfsr_addr_cfg_arbiter.sv
// Bench for lfsr_addr_cfg_arbiter: a behavioural AXI4-Lite slave with
// programmable ready delays, per-requester expectation queues and checks.
module tb_lfsr_addr_cfg_arbiter;
  import lfsr_addr_cfg_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            tb_valid [2];
  logic            tb_we    [2];
  logic [AW-1:0]   tb_addr  [2];
  logic [DW-1:0]   tb_wdata [2];
  logic [1:0]      tb_rsp_ready;

  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;

  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0]   m_wdata;
  logic [3:0]      m_wstrb;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [DW-1:0]   rdata;

  assign req_valid = {tb_valid[1], tb_valid[0]};
  assign req_we    = {tb_we[1], tb_we[0]};
  assign req_addr  = {tb_addr[1], tb_addr[0]};
  assign req_wdata = {tb_wdata[1], tb_wdata[0]};

  lfsr_addr_cfg_arbiter #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(tb_rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(m_rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural slave (decides at negedge) ----------------
  logic [DW-1:0] smem [4];
  int            aw_delay, w_delay, aw_cnt, w_cnt, aw_beats, w_beats;
  logic          aw_got, w_got, ar_got, b_fire, r_fire;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    rresp_force;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0;
    end else begin
      if (awready) begin awready = 0; aw_got = 1; aw_cnt = 0; end
      if (wready)  begin wready = 0;  w_got = 1;  w_cnt = 0;  end
      if (arready) begin arready = 0; ar_got = 1; end
      if (b_fire)  begin bvalid = 0;  b_fire = 0; end
      if (r_fire)  begin rvalid = 0;  r_fire = 0; end
      if (aw_got && w_got) begin
        smem[s_awaddr[3:2]] = s_wdata;
        bvalid = 1; bresp = OKAY; aw_got = 0; w_got = 0;
      end
      if (ar_got) begin
        rvalid = 1; rdata = smem[s_araddr[3:2]]; rresp = rresp_force; ar_got = 0;
      end
      if (m_awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) begin awready = 1; s_awaddr = m_awaddr; aw_beats++; end
        else aw_cnt++;
      end
      if (m_wvalid && !w_got) begin
        if (w_cnt >= w_delay) begin wready = 1; s_wdata = m_wdata; w_beats++; end
        else w_cnt++;
      end
      if (m_arvalid && !ar_got) begin arready = 1; s_araddr = m_araddr; end
      if (bvalid && m_bready) b_fire = 1;
      if (rvalid && m_rready) r_fire = 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic [DW-1:0] rdata; logic [1:0] resp; bit lat; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   cyc = 0;
  int   gcyc [2];
  logic [1:0] rsp_prev;
  int   n_rsp = 0;
  bit   saw_split = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   got;
    if (!rst_n) begin
      rsp_prev = 2'b00;
    end else begin
      cyc++;
      check("req_ready_onehot", ($countones(req_ready) <= 1), 1);
      check("ar_aw_exclusive", m_arvalid & (m_awvalid | m_wvalid), 0);
      if (m_awvalid) check("awaddr_align_prot", {m_awaddr[1:0], m_awprot}, 0);
      if (m_arvalid) check("araddr_align_prot", {m_araddr[1:0], m_arprot}, 0);
      if (m_wvalid)  check("wstrb", m_wstrb, 4'hF);
      if (m_awvalid && !m_wvalid) saw_split = 1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          gcyc[i] = cyc;
        end
        if (rsp_valid[i] && !rsp_prev[i]) begin
          if (i == 0 && q0.size() > 0 && q0[0].lat) check("latency_req0", cyc - gcyc[0], 3);
          if (i == 1 && q1.size() > 0 && q1[0].lat) check("latency_req1", cyc - gcyc[1], 3);
        end
        if (rsp_valid[i] && tb_rsp_ready[i]) begin
          got = 0;
          if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
          if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
          if (!got) begin
            check("unexpected_rsp", i + 1, 0);
          end else begin
            n_rsp++;
            $display("rsp req%0d rdata=%08h resp=%b", i, rsp_rdata, rsp_resp);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
          end
        end
      end
      rsp_prev = rsp_valid;
    end
  end

  // ---------------- requester driver ----------------
  task automatic do_cmd(input int i, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] er,
                        input logic [1:0] eresp, input bit lat);
    exp_t e;
    bit   ok = 0;
    e.rdata = er; e.resp = eresp; e.lat = lat;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    tb_valid[i] = 1; tb_we[i] = we; tb_addr[i] = addr; tb_wdata[i] = wdata;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
      @(posedge clk); #1;
    end
    tb_valid[i] = 0;
    if (!ok) begin
      check("grant_timeout", i, 99);
      if (i == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && rsp_valid == 2'b00) done = 1;
    end
    if (!done) check("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  function automatic logic [11:0] all_outs();
    return {req_ready, rsp_valid, rsp_resp, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, |rsp_rdata};
  endfunction

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] er; logic [1:0] eresp; } vec_t;
  vec_t vt [9];

  initial begin
    int   base;
    logic [DW-1:0] held;
    vt[0] = '{1'b1, REG0, 32'h1, 32'h0, OKAY};
    vt[1] = '{1'b1, REG1, 32'h2, 32'h0, OKAY};
    vt[2] = '{1'b1, REG2, 32'h3, 32'h0, OKAY};
    vt[3] = '{1'b1, REG3, 32'h4, 32'h0, OKAY};
    vt[4] = '{1'b0, REG0, 32'h0, 32'h1, OKAY};
    vt[5] = '{1'b0, REG1, 32'h0, 32'h2, OKAY};
    vt[6] = '{1'b0, REG2, 32'h0, 32'h3, OKAY};
    vt[7] = '{1'b0, REG3, 32'h0, 32'h4, OKAY};
    vt[8] = '{1'b0, 4'h9, 32'h0, 32'h3, OKAY};

    for (int i = 0; i < 2; i++) begin
      tb_valid[i] = 1; tb_we[i] = 0; tb_addr[i] = '0; tb_wdata[i] = '0;
    end
    for (int i = 0; i < 4; i++) smem[i] = '0;
    tb_rsp_ready = 2'b11;
    aw_delay = 0; w_delay = 0; aw_beats = 0; w_beats = 0; rresp_force = OKAY;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = OKAY; rresp = OKAY; rdata = '0;

    // Reset state, with commands pending on both requesters.
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", all_outs(), 0);
    tb_valid[0] = 0; tb_valid[1] = 0;
    rst_n = 1;

    // Single requester: writes then read-backs, zero-wait slave.
    for (int k = 0; k < 9; k++) begin
      do_cmd(0, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].er, vt[k].eresp, 1'b1);
      wait_idle();
    end

    // Requester 1 alone, leaves last_grant = 1.
    do_cmd(1, 1'b0, REG2, 32'h0, 32'h3, OKAY, 1'b1);
    wait_idle();

    // Both requesters streaming: grants alternate starting with 0.
    grant_log.delete();
    fork
      begin
        do_cmd(0, 1'b0, REG0, 32'h0, 32'h1, OKAY, 1'b0);
        do_cmd(0, 1'b0, REG0, 32'h0, 32'h1, OKAY, 1'b0);
      end
      begin
        do_cmd(1, 1'b1, REG1, 32'hA5A5A5A5, 32'h0, OKAY, 1'b0);
        do_cmd(1, 1'b1, REG1, 32'hA5A5A5A5, 32'h0, OKAY, 1'b0);
      end
    join
    wait_idle();
    check("grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check("grant_order", grant_log[k], k % 2);

    // Slow AW (3 cycles) and W (1 cycle).
    aw_delay = 3; w_delay = 1; aw_beats = 0; w_beats = 0; saw_split = 0;
    base = n_rsp;
    do_cmd(0, 1'b1, REG3, 32'h44, 32'h0, OKAY, 1'b0);
    wait_idle();
    check("aw_beats", aw_beats, 1);
    check("w_beats", w_beats, 1);
    check("w_drops_before_aw", saw_split, 1);
    check("single_rsp", n_rsp - base, 1);
    aw_delay = 0; w_delay = 0;

    // Owner stalls the response; the other requester must wait.
    tb_rsp_ready[0] = 0;
    fork
      do_cmd(0, 1'b0, REG0, 32'h0, 32'h1, OKAY, 1'b0);
      begin
        repeat (2) @(posedge clk); #1;
        do_cmd(1, 1'b1, REG2, 32'h33, 32'h0, OKAY, 1'b0);
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (rsp_valid[0]) seen = 1;
        end
        check("stall_rsp_seen", seen, 1);
        held = rsp_rdata;
        check("stall_rdata_first", held, 32'h1);
        repeat (5) begin
          @(negedge clk);
          check("stall_rsp_valid", rsp_valid, 2'b01);
          check("stall_rdata", rsp_rdata, held);
          check("stall_no_axi", {m_awvalid, m_wvalid, m_arvalid, req_ready[1]}, 0);
        end
        @(posedge clk); #1;
        tb_rsp_ready[0] = 1;
      end
    join
    wait_idle();

    // Error response passes through, next command is normal.
    rresp_force = SLVERR;
    do_cmd(0, 1'b0, REG3, 32'h0, 32'h44, SLVERR, 1'b0);
    wait_idle();
    rresp_force = OKAY;
    do_cmd(1, 1'b0, REG1, 32'h0, 32'hA5A5A5A5, OKAY, 1'b1);
    wait_idle();

    // Reset while awvalid is up: outputs clear asynchronously.
    aw_delay = 20;
    do_cmd(0, 1'b1, REG3, 32'hDEAD, 32'h0, OKAY, 1'b0);
    begin
      bit seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (m_awvalid) seen = 1;
      end
      check("awvalid_before_reset", seen, 1);
    end
    #2 rst_n = 0;
    #1 check("async_reset_outputs", all_outs(), 0);
    q0.delete(); q1.delete(); grant_log.delete();
    aw_delay = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    fork
      do_cmd(0, 1'b1, REG0, 32'h11, 32'h0, OKAY, 1'b0);
      do_cmd(1, 1'b1, REG1, 32'h22, 32'h0, OKAY, 1'b0);
    join
    wait_idle();
    check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
    do_cmd(1, 1'b0, REG0, 32'h0, 32'h11, OKAY, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
